// File: rtl/signal_head_monitor_if.sv
// Bus between the traffic-light controller, the signal head monitor and the lamp drivers.
// The controller side is the master; the monitor is the slave.
interface signal_head_monitor_if;
  logic [2:0] lit_a_in;
  logic [2:0] lit_b_in;
  logic       clr_fault;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  modport master (
    output lit_a_in, lit_b_in, clr_fault,
    input  lamp_a, lamp_b, fault, fault_code, fault_count
  );

  modport slave (
    input  lit_a_in, lit_b_in, clr_fault,
    output lamp_a, lamp_b, fault, fault_code, fault_count
  );
endinterface

// File: rtl/signal_head_monitor.sv
// Safety monitor between the light controller and the lamp drivers.
// Passes legal light codes to the lamps and forces flashing red on any violation.
module signal_head_monitor #(
  parameter int unsigned YELLOW_MIN = 1,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  signal_head_monitor_if.slave  bus
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  localparam logic [2:0] C_NONE         = 3'd0;
  localparam logic [2:0] C_ILLEGAL      = 3'd1;
  localparam logic [2:0] C_CONFLICT     = 3'd2;
  localparam logic [2:0] C_BAD_SEQ      = 3'd3;
  localparam logic [2:0] C_SHORT_YELLOW = 3'd4;

  localparam int unsigned YW = $clog2(YELLOW_MIN + 1);
  localparam int unsigned FW = $clog2(2 * FLASH_HALF);

  typedef enum logic [1:0] {NORMAL, FLASH, RESYNC} state_t;

  state_t        state_q, state_n;
  logic [2:0]    lamp_a_q, lamp_a_n, lamp_b_q, lamp_b_n;
  logic [2:0]    prev_a_q, prev_a_n, prev_b_q, prev_b_n;
  logic          fault_q, fault_n;
  logic [2:0]    code_q, code_n;
  logic [7:0]    count_q, count_n;
  logic [YW-1:0] ycnt_a_q, ycnt_a_n, ycnt_b_q, ycnt_b_n;
  logic [FW-1:0] flash_q, flash_n;
  logic [2:0]    hit_code;
  logic          resync_ok;

  function automatic logic is_legal(input logic [2:0] x);
    return (x == RED) || (x == YELLOW) || (x == GREEN);
  endfunction

  function automatic logic step_ok(input logic [2:0] p, input logic [2:0] n);
    return (n == p) || (p == GREEN && n == YELLOW) ||
           (p == YELLOW && n == RED) || (p == RED && n == GREEN);
  endfunction

  // Consecutive-yellow count, saturating at YELLOW_MIN, reloaded to 1 on entry
  function automatic logic [YW-1:0] ycnt_next(input logic [YW-1:0] cnt, input logic [2:0] x);
    if (x != YELLOW)                       return '0;
    else if (cnt == '0)                    return YW'(1);
    else if (cnt >= YW'(YELLOW_MIN))       return cnt;
    else                                   return cnt + YW'(1);
  endfunction

  // Violation detection, highest-priority cause wins
  always_comb begin
    hit_code = C_NONE;
    if (!is_legal(bus.lit_a_in) || !is_legal(bus.lit_b_in))
      hit_code = C_ILLEGAL;
    else if (bus.lit_a_in != RED && bus.lit_b_in != RED)
      hit_code = C_CONFLICT;
    else if (!step_ok(prev_a_q, bus.lit_a_in) || !step_ok(prev_b_q, bus.lit_b_in))
      hit_code = C_BAD_SEQ;
    else if ((prev_a_q == YELLOW && bus.lit_a_in == RED && ycnt_a_q < YW'(YELLOW_MIN)) ||
             (prev_b_q == YELLOW && bus.lit_b_in == RED && ycnt_b_q < YW'(YELLOW_MIN)))
      hit_code = C_SHORT_YELLOW;
  end

  assign resync_ok = (bus.lit_a_in == RED || bus.lit_a_in == GREEN) &&
                     (bus.lit_b_in == RED || bus.lit_b_in == GREEN) &&
                     !(bus.lit_a_in == GREEN && bus.lit_b_in == GREEN);

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state_q;
    lamp_a_n = lamp_a_q;
    lamp_b_n = lamp_b_q;
    prev_a_n = prev_a_q;
    prev_b_n = prev_b_q;
    fault_n  = fault_q;
    code_n   = code_q;
    count_n  = count_q;
    flash_n  = flash_q;
    ycnt_a_n = ycnt_next(ycnt_a_q, bus.lit_a_in);
    ycnt_b_n = ycnt_next(ycnt_b_q, bus.lit_b_in);

    case (state_q)
      NORMAL: begin
        prev_a_n = bus.lit_a_in;
        prev_b_n = bus.lit_b_in;
        if (hit_code != C_NONE) begin
          state_n  = FLASH;
          lamp_a_n = RED;
          lamp_b_n = RED;
          fault_n  = 1'b1;
          code_n   = hit_code;
          count_n  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          flash_n  = '0;
        end else begin
          lamp_a_n = bus.lit_a_in;
          lamp_b_n = bus.lit_b_in;
        end
      end
      FLASH: begin
        if (bus.clr_fault) begin
          state_n  = RESYNC;
          lamp_a_n = RED;
          lamp_b_n = RED;
          prev_a_n = RED;
          prev_b_n = RED;
        end else begin
          flash_n  = (flash_q == FW'(2 * FLASH_HALF - 1)) ? '0 : flash_q + FW'(1);
          lamp_a_n = (flash_n < FW'(FLASH_HALF)) ? RED : OFF;
          lamp_b_n = lamp_a_n;
        end
      end
      RESYNC: begin
        if (resync_ok) begin
          state_n  = NORMAL;
          lamp_a_n = bus.lit_a_in;
          lamp_b_n = bus.lit_b_in;
          prev_a_n = bus.lit_a_in;
          prev_b_n = bus.lit_b_in;
          fault_n  = 1'b0;
          code_n   = C_NONE;
        end else begin
          lamp_a_n = RED;
          lamp_b_n = RED;
          prev_a_n = RED;
          prev_b_n = RED;
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NORMAL;
      lamp_a_q <= RED;
      lamp_b_q <= RED;
      prev_a_q <= RED;
      prev_b_q <= RED;
      fault_q  <= 1'b0;
      code_q   <= C_NONE;
      count_q  <= 8'd0;
      ycnt_a_q <= '0;
      ycnt_b_q <= '0;
      flash_q  <= '0;
    end else begin
      state_q  <= state_n;
      lamp_a_q <= lamp_a_n;
      lamp_b_q <= lamp_b_n;
      prev_a_q <= prev_a_n;
      prev_b_q <= prev_b_n;
      fault_q  <= fault_n;
      code_q   <= code_n;
      count_q  <= count_n;
      ycnt_a_q <= ycnt_a_n;
      ycnt_b_q <= ycnt_b_n;
      flash_q  <= flash_n;
    end
  end

  assign bus.lamp_a      = lamp_a_q;
  assign bus.lamp_b      = lamp_b_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.fault_count = count_q;

endmodule
